// File: rtl/poly_voice_allocator.sv
// rtl/poly_voice_allocator.sv - polyphonic voice allocator with command FIFO and oldest-voice stealing
// Ports:
//   clk, reset (async, active-low)
//   avs_s0_write/avs_s0_writedata : note command push ([15]=on, [14:8]=note, [7:0]=velocity)
//   avs_s0_read/avs_s0_readdata   : status word (active mask, overflow, FIFO count, busy FSM)
//   o_voice_active/note/vel       : per-voice state for the oscillator bank
//   o_voice_start/o_voice_stop    : one-cycle per-voice pulses
//   o_busy                        : FSM not idle or FIFO non-empty
module poly_voice_allocator #(
    parameter int VOICES        = 8,
    parameter int NOTE_W        = 7,
    parameter int VEL_W         = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int STOP_ALL_NOTE = 127,
    parameter int AGE_W         = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     avs_s0_write,
    input  logic [31:0]              avs_s0_writedata,
    input  logic                     avs_s0_read,
    output logic [31:0]              avs_s0_readdata,
    output logic [VOICES-1:0]        o_voice_active,
    output logic [VOICES*NOTE_W-1:0] o_voice_note,
    output logic [VOICES*VEL_W-1:0]  o_voice_vel,
    output logic [VOICES-1:0]        o_voice_start,
    output logic [VOICES-1:0]        o_voice_stop,
    output logic                     o_busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MATCH, S_APPLY} state_t;

    state_t              r_state, w_state_nxt;
    logic [15:0]         r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr, r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;
    logic [15:0]         r_cmd;
    logic [VOICES-1:0]   r_active, r_start, r_stop;
    logic [NOTE_W-1:0]   r_note [VOICES];
    logic [VEL_W-1:0]    r_vel  [VOICES];
    logic [AGE_W-1:0]    r_age  [VOICES];
    logic                r_match_ok, r_free_ok;
    logic [IDX_W-1:0]    r_match_idx, r_free_idx, r_old_idx;

    logic                w_full, w_push, w_pop, w_ovf_set;
    logic                w_cmd_on, w_steal;
    logic [NOTE_W-1:0]   w_cmd_note;
    logic [VEL_W-1:0]    w_cmd_vel;
    logic                w_match_ok, w_free_ok, w_old_ok;
    logic [IDX_W-1:0]    w_match_idx, w_free_idx, w_old_idx, w_tgt;
    logic [AGE_W-1:0]    w_old_age;
    logic [2:0]          w_cnt_sat;
    logic                w_unused_wdata;

    assign w_unused_wdata = ^avs_s0_writedata[31:16];

    // Fullness is judged on the pre-edge count, so a write into a full FIFO is lost
    // even when the FSM pops in the same cycle.
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push    = avs_s0_write && !w_full;
    assign w_ovf_set = avs_s0_write && w_full;

    assign w_cmd_on   = r_cmd[15];
    assign w_cmd_note = NOTE_W'(r_cmd[14:8]);
    assign w_cmd_vel  = VEL_W'(r_cmd[7:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_MATCH;
                end
            end
            S_MATCH: w_state_nxt = S_APPLY;
            S_APPLY: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= avs_s0_writedata[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_cmd   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_cmd  <= r_fifo[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A read clears the sticky flag, but an overflow in the same cycle wins.
            r_ovf <= avs_s0_read ? w_ovf_set : (r_ovf | w_ovf_set);
        end
    end

    // Voice search over the current tables; the tables only change in APPLY, so the
    // results registered in MATCH are still valid when APPLY uses them.
    always_comb begin
        w_match_ok  = 1'b0;
        w_match_idx = '0;
        w_free_ok   = 1'b0;
        w_free_idx  = '0;
        w_old_ok    = 1'b0;
        w_old_idx   = '0;
        w_old_age   = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (!w_match_ok && r_active[i] && (r_note[i] == w_cmd_note)) begin
                w_match_ok  = 1'b1;
                w_match_idx = IDX_W'(i);
            end
            if (!w_free_ok && !r_active[i]) begin
                w_free_ok  = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            // Strict greater-than keeps the lowest index on equal ages.
            if (r_active[i] && (!w_old_ok || (r_age[i] > w_old_age))) begin
                w_old_ok  = 1'b1;
                w_old_idx = IDX_W'(i);
                w_old_age = r_age[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_match_ok  <= 1'b0;
            r_free_ok   <= 1'b0;
            r_match_idx <= '0;
            r_free_idx  <= '0;
            r_old_idx   <= '0;
        end else if (r_state == S_MATCH) begin
            r_match_ok  <= w_match_ok;
            r_free_ok   <= w_free_ok;
            r_match_idx <= w_match_idx;
            r_free_idx  <= w_free_idx;
            r_old_idx   <= w_old_idx;
        end
    end

    assign w_steal = !r_match_ok && !r_free_ok;
    assign w_tgt   = r_match_ok ? r_match_idx : (r_free_ok ? r_free_idx : r_old_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active <= '0;
            r_start  <= '0;
            r_stop   <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_note[i] <= '0;
                r_vel[i]  <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            r_start <= '0;
            r_stop  <= '0;
            if (r_state == S_APPLY) begin
                if (w_cmd_on) begin
                    // Age every active voice; the target's age is overridden below.
                    for (int i = 0; i < VOICES; i++) begin
                        if (r_active[i] && (r_age[i] != {AGE_W{1'b1}})) begin
                            r_age[i] <= r_age[i] + 1'b1;
                        end
                    end
                    r_active[w_tgt] <= 1'b1;
                    r_note[w_tgt]   <= w_cmd_note;
                    r_vel[w_tgt]    <= w_cmd_vel;
                    r_age[w_tgt]    <= '0;
                    r_start[w_tgt]  <= 1'b1;
                    r_stop[w_tgt]   <= w_steal;
                end else if (w_cmd_note == NOTE_W'(STOP_ALL_NOTE)) begin
                    r_stop   <= r_active;
                    r_active <= '0;
                    for (int i = 0; i < VOICES; i++) begin
                        r_age[i] <= '0;
                    end
                end else if (r_match_ok) begin
                    r_active[r_match_idx] <= 1'b0;
                    r_stop[r_match_idx]   <= 1'b1;
                    r_age[r_match_idx]    <= '0;
                end
            end
        end
    end

    always_comb begin
        o_voice_note = '0;
        o_voice_vel  = '0;
        for (int i = 0; i < VOICES; i++) begin
            o_voice_note[i*NOTE_W +: NOTE_W] = r_note[i];
            o_voice_vel[i*VEL_W +: VEL_W]    = r_vel[i];
        end
    end

    assign w_cnt_sat = (32'(r_count) > 32'd7) ? 3'd7 : 3'(r_count);

    always_comb begin
        avs_s0_readdata        = '0;
        avs_s0_readdata[15:0]  = 16'(r_active);
        avs_s0_readdata[16]    = r_ovf;
        avs_s0_readdata[19:17] = w_cnt_sat;
        avs_s0_readdata[20]    = (r_state != S_IDLE);
    end

    assign o_voice_active = r_active;
    assign o_voice_start  = r_start;
    assign o_voice_stop   = r_stop;
    assign o_busy         = (r_state != S_IDLE) || (r_count != '0);

endmodule
